tdc_reg_responder: RTL and testbench

TDC_REG_RESPONDER -- requirements
Module: tdc_reg_responder

---
 rtl/tdc_reg_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_tdc_reg_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_reg_responder.sv
// ---------------------------------------------------------------------------
// tdc_reg_responder
//
// Register-bus target for the TDC block. It decodes a host bus made of
// active-low strobes (chip select, write and read). It holds eight read/write
// config registers, four result registers loaded from a side port, a status
// word with access counters and error flags, a clear command and a fixed ID.
// Every committed config write is echoed on a one-cycle notification port.
//
// Ports
//   clk, reset          : sole clock, synchronous active-high reset
//   csn_in/wrn_in/rdn_in: active-low chip select, write and read strobes
//   addr_in, data_in    : register address and write data from the bus
//   data_out, data_oe   : registered read data and bus-drive enable
//   res_load/idx/data   : side-port load of result registers 8..11
//   cfg_wr_pulse/addr/data : one-cycle echo of each committed config write
// ---------------------------------------------------------------------------
module tdc_reg_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        csn_in,
    input  logic        wrn_in,
    input  logic        rdn_in,
    input  logic [3:0]  addr_in,
    input  logic [27:0] data_in,
    output logic [27:0] data_out,
    output logic        data_oe,
    input  logic        res_load,
    input  logic [1:0]  res_idx,
    input  logic [27:0] res_data,
    output logic        cfg_wr_pulse,
    output logic [2:0]  cfg_wr_addr,
    output logic [27:0] cfg_wr_data
);

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [3:0]  ADDR_STATUS = 4'd12;
    localparam logic [3:0]  ADDR_CLEAR  = 4'd13;
    localparam logic [3:0]  ADDR_ID     = 4'd14;
    localparam logic [27:0] ID_VALUE    = 28'h7DC0001;

    logic [2:0]  state_q, state_d;
    logic [27:0] cfg_q [0:7];
    logic [27:0] cfg_d [0:7];
    logic [27:0] res_q [0:3];
    logic [27:0] res_d [0:3];
    logic [7:0]  wr_count_q, wr_count_d;
    logic [7:0]  rd_count_q, rd_count_d;
    logic        conflict_err_q, conflict_err_d;
    logic        ro_err_q, ro_err_d;
    logic [27:0] data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic        cfg_wr_pulse_q, cfg_wr_pulse_d;
    logic [2:0]  cfg_wr_addr_q, cfg_wr_addr_d;
    logic [27:0] cfg_wr_data_q, cfg_wr_data_d;

    logic        wr_commit;
    logic        rd_start;
    logic        err_entry;
    logic        read_req;
    logic [27:0] status_word;
    logic [27:0] rd_mux;

    // -----------------------------------------------------------------------
    // Bus FSM. SYNC is entered from reset and waits for csn_in high, so an
    // access that was already in flight when reset hit is never honoured.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch cannot be inferred.
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (csn_in) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!csn_in) begin
                    if (!wrn_in && !rdn_in)     state_d = ST_ERR;
                    else if (!wrn_in)           state_d = ST_WR;
                    else if (!rdn_in)           state_d = ST_RD;
                end
            end
            // Releasing the own strobe is a clean end of the access even if
            // the other strobe falls on the same edge; only an overlap of
            // both strobes is a conflict.
            ST_WR: begin
                if (csn_in || wrn_in)           state_d = ST_IDLE;
                else if (!rdn_in)               state_d = ST_ERR;
            end
            ST_RD: begin
                if (csn_in || rdn_in)           state_d = ST_IDLE;
                else if (!wrn_in)               state_d = ST_ERR;
            end
            ST_ERR: begin
                if (csn_in || (wrn_in && rdn_in)) state_d = ST_IDLE;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign wr_commit = (state_q == ST_IDLE) && (state_d == ST_WR);
    assign rd_start  = (state_q == ST_IDLE) && (state_d == ST_RD);
    assign err_entry = (state_d == ST_ERR) && (state_q != ST_ERR);

    // A clean read strobe is served from any state that is not waiting for
    // resync or sitting in a conflict; the drive follows one clock later.
    assign read_req = (state_q != ST_SYNC) && (state_q != ST_ERR) &&
                      !csn_in && !rdn_in && wrn_in;

    assign status_word = {10'd0, ro_err_q, conflict_err_q, rd_count_q, wr_count_q};

    // Read mux works on current register contents, so a result load landing
    // on the same edge as a read returns the value from before the load.
    always_comb begin
        rd_mux = '0;
        if (!addr_in[3]) begin
            rd_mux = cfg_q[addr_in[2:0]];
        end else begin
            case (addr_in)
                4'd8, 4'd9, 4'd10, 4'd11: rd_mux = res_q[addr_in[1:0]];
                ADDR_STATUS:              rd_mux = status_word;
                ADDR_ID:                  rd_mux = ID_VALUE;
                default:                  rd_mux = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register file, counters, flags and output staging
    // -----------------------------------------------------------------------
    always_comb begin
        cfg_d          = cfg_q;
        res_d          = res_q;
        wr_count_d     = wr_count_q;
        rd_count_d     = rd_count_q;
        conflict_err_d = conflict_err_q;
        ro_err_d       = ro_err_q;
        cfg_wr_pulse_d = 1'b0;
        cfg_wr_addr_d  = cfg_wr_addr_q;
        cfg_wr_data_d  = cfg_wr_data_q;
        data_oe_d      = read_req;
        data_out_d     = read_req ? rd_mux : 28'd0;

        if (res_load) begin
            res_d[res_idx] = res_data;
        end

        if (rd_start) begin
            rd_count_d = rd_count_q + 8'd1;
        end

        if (err_entry) begin
            conflict_err_d = 1'b1;
        end

        if (wr_commit) begin
            wr_count_d = wr_count_q + 8'd1;
            if (!addr_in[3]) begin
                cfg_d[addr_in[2:0]] = data_in;
                cfg_wr_pulse_d      = 1'b1;
                cfg_wr_addr_d       = addr_in[2:0];
                cfg_wr_data_d       = data_in;
            end else if (addr_in == ADDR_CLEAR) begin
                // The clear overrides the increment this same write made.
                wr_count_d     = 8'd0;
                rd_count_d     = 8'd0;
                conflict_err_d = 1'b0;
                ro_err_d       = 1'b0;
            end else begin
                ro_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q        <= ST_SYNC;
            // NOTE: the register arrays are small flop banks that must read
            // as zero after reset, so they are reset explicitly rather than
            // being treated as an unreset RAM.
            for (int i = 0; i < 8; i++) cfg_q[i] <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
            wr_count_q     <= '0;
            rd_count_q     <= '0;
            conflict_err_q <= 1'b0;
            ro_err_q       <= 1'b0;
            data_out_q     <= '0;
            data_oe_q      <= 1'b0;
            cfg_wr_pulse_q <= 1'b0;
            cfg_wr_addr_q  <= '0;
            cfg_wr_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cfg_q          <= cfg_d;
            res_q          <= res_d;
            wr_count_q     <= wr_count_d;
            rd_count_q     <= rd_count_d;
            conflict_err_q <= conflict_err_d;
            ro_err_q       <= ro_err_d;
            data_out_q     <= data_out_d;
            data_oe_q      <= data_oe_d;
            cfg_wr_pulse_q <= cfg_wr_pulse_d;
            cfg_wr_addr_q  <= cfg_wr_addr_d;
            cfg_wr_data_q  <= cfg_wr_data_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;
    assign cfg_wr_pulse = cfg_wr_pulse_q;
    assign cfg_wr_addr  = cfg_wr_addr_q;
    assign cfg_wr_data  = cfg_wr_data_q;

endmodule

// File: tb/tb_tdc_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_tdc_reg_responder
//
// Directed stimulus for the register-bus responder. Each bus read pushes its
// expected data into rd_exp_q and each config write pushes its expected echo
// into cfg_exp_q. A monitor on the falling clock edge pops and compares
// whenever the DUT drives the bus or pulses the config echo.
// ---------------------------------------------------------------------------
module tb_tdc_reg_responder;

    logic        clk;
    logic        reset;
    logic        csn_in, wrn_in, rdn_in;
    logic [3:0]  addr_in;
    logic [27:0] data_in;
    logic [27:0] data_out;
    logic        data_oe;
    logic        res_load;
    logic [1:0]  res_idx;
    logic [27:0] res_data;
    logic        cfg_wr_pulse;
    logic [2:0]  cfg_wr_addr;
    logic [27:0] cfg_wr_data;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    logic [27:0] rd_exp_q  [$];
    logic [30:0] cfg_exp_q [$];

    tdc_reg_responder dut (
        .clk          (clk),
        .reset        (reset),
        .csn_in       (csn_in),
        .wrn_in       (wrn_in),
        .rdn_in       (rdn_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .res_load     (res_load),
        .res_idx      (res_idx),
        .res_data     (res_data),
        .cfg_wr_pulse (cfg_wr_pulse),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard side, decoupled from the stimulus.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_oe) begin
                if (rd_exp_q.size() == 0) check("unexpected_data_oe", {31'd0, data_oe}, 32'd0);
                else                      check("read_data", {4'd0, data_out}, {4'd0, rd_exp_q.pop_front()});
            end else begin
                check("idle_data_out_zero", {4'd0, data_out}, 32'd0);
            end
            if (cfg_wr_pulse) begin
                if (cfg_exp_q.size() == 0) check("unexpected_cfg_wr_pulse", {31'd0, cfg_wr_pulse}, 32'd0);
                else check("cfg_wr_echo", {1'b0, cfg_wr_addr, cfg_wr_data}, {1'b0, cfg_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [3:0] a, input logic [27:0] d);
        if (!a[3]) cfg_exp_q.push_back({a[2:0], d});
        @(posedge clk); #1;
        csn_in = 1'b0; wrn_in = 1'b0; addr_in = a; data_in = d;
        @(posedge clk); #1;
        csn_in = 1'b1; wrn_in = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [27:0] exp);
        rd_exp_q.push_back(exp);
        @(posedge clk); #1;
        csn_in = 1'b0; rdn_in = 1'b0; addr_in = a;
        @(posedge clk); #1;
        csn_in = 1'b1; rdn_in = 1'b1;
        @(negedge clk);
        check("read_latency_oe", {31'd0, data_oe}, 32'd1);
    endtask

    task automatic side_load(input logic [1:0] idx, input logic [27:0] d);
        @(posedge clk); #1;
        res_load = 1'b1; res_idx = idx; res_data = d;
        @(posedge clk); #1;
        res_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        csn_in = 1'b1; wrn_in = 1'b1; rdn_in = 1'b1;
        addr_in = '0; data_in = '0;
        res_load = 1'b0; res_idx = '0; res_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", {4'd0, data_out}, 32'd0);
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_cfg_wr_pulse", {31'd0, cfg_wr_pulse}, 32'd0);
        check("rst_cfg_wr_addr", {29'd0, cfg_wr_addr}, 32'd0);
        check("rst_cfg_wr_data", {4'd0, cfg_wr_data}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Basic write/read and status
        bus_write(4'd3, 28'h0ABCDEF);
        bus_read(4'd3, 28'h0ABCDEF);
        bus_read(4'd12, 28'h0000101);     // wr=1 rd=1

        // Fixed and empty addresses
        bus_read(4'd14, 28'h7DC0001);
        bus_read(4'd13, 28'h0000000);
        bus_read(4'd15, 28'h0000000);     // rd now 5

        // Result register load, read-only write
        side_load(2'd2, 28'h1234567);
        bus_read(4'd10, 28'h1234567);     // rd 6
        bus_write(4'd10, 28'h0000000);    // wr 2, ro_err
        bus_read(4'd10, 28'h1234567);     // rd 7
        bus_read(4'd12, 28'h0020702);     // ro=1 rd=7 wr=2, rd -> 8

        // Side load on the same edge as a read returns the old value
        rd_exp_q.push_back(28'h1234567);
        @(posedge clk); #1;
        csn_in = 1'b0; rdn_in = 1'b0; addr_in = 4'd10;
        res_load = 1'b1; res_idx = 2'd2; res_data = 28'h7654321;
        @(posedge clk); #1;
        csn_in = 1'b1; rdn_in = 1'b1; res_load = 1'b0;
        @(negedge clk);
        check("read_latency_oe", {31'd0, data_oe}, 32'd1);   // rd 9
        bus_read(4'd10, 28'h7654321);     // rd 10

        // All strobes low: conflict, no write, no drive
        @(posedge clk); #1;
        csn_in = 1'b0; wrn_in = 1'b0; rdn_in = 1'b0; addr_in = 4'd3; data_in = 28'hFFFFFFF;
        @(posedge clk); #1;
        @(negedge clk);
        check("err_no_drive", {31'd0, data_oe}, 32'd0);
        @(posedge clk); #1;
        csn_in = 1'b1; wrn_in = 1'b1; rdn_in = 1'b1;
        bus_read(4'd3, 28'h0ABCDEF);      // rd 11
        bus_read(4'd12, 28'h0030B02);     // conf=1 ro=1 rd=11 wr=2, rd -> 12
        bus_write(4'd13, 28'h0000000);    // clear
        bus_read(4'd12, 28'h0000000);     // rd -> 1

        // Read strobe falls while a write is still held: one commit, conflict
        cfg_exp_q.push_back({3'd5, 28'h5555555});
        @(posedge clk); #1;
        csn_in = 1'b0; wrn_in = 1'b0; addr_in = 4'd5; data_in = 28'h5555555;
        @(posedge clk); #1;
        rdn_in = 1'b0;
        @(posedge clk); #1;
        csn_in = 1'b1; wrn_in = 1'b1; rdn_in = 1'b1;
        bus_read(4'd5, 28'h5555555);      // rd 2
        bus_read(4'd12, 28'h0010201);     // conf=1 rd=2 wr=1, rd -> 3

        // Chip select held low, three write strobes -> three commits
        cfg_exp_q.push_back({3'd6, 28'h1111111});
        cfg_exp_q.push_back({3'd6, 28'h2222222});
        cfg_exp_q.push_back({3'd6, 28'h3333333});
        @(posedge clk); #1;
        csn_in = 1'b0; wrn_in = 1'b0; addr_in = 4'd6; data_in = 28'h1111111;
        @(posedge clk); #1; wrn_in = 1'b1;
        @(posedge clk); #1; wrn_in = 1'b0; data_in = 28'h2222222;
        @(posedge clk); #1; wrn_in = 1'b1;
        @(posedge clk); #1; wrn_in = 1'b0; data_in = 28'h3333333;
        @(posedge clk); #1; wrn_in = 1'b1; csn_in = 1'b1;
        bus_read(4'd6, 28'h3333333);      // rd 4
        bus_read(4'd12, 28'h0010404);     // conf=1 rd=4 wr=4, rd -> 5
        bus_write(4'd13, 28'h0000000);    // clear: all zero

        // Write counter wrap
        for (int i = 0; i < 255; i++) bus_write(4'd0, 28'(i));
        bus_read(4'd12, 28'h00000FF);     // wr=255 rd=0, rd -> 1
        bus_write(4'd0, 28'h00000FF);     // wr wraps to 0
        bus_read(4'd12, 28'h0000100);     // wr=0 rd=1, no flags, rd -> 2
        bus_read(4'd0, 28'h00000FF);

        // Reset in the middle of a write access
        @(posedge clk); #1;
        reset = 1'b1; csn_in = 1'b0; wrn_in = 1'b0; addr_in = 4'd1; data_in = 28'h0BADBAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_cfg_wr_data", {4'd0, cfg_wr_data}, 32'd0);
        check("midrst_data_oe", {31'd0, data_oe}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        csn_in = 1'b1; wrn_in = 1'b1;
        bus_write(4'd1, 28'h0600D01);
        bus_read(4'd1, 28'h0600D01);      // rd 1
        bus_read(4'd3, 28'h0000000);      // config cleared by reset, rd 2
        bus_read(4'd10, 28'h0000000);     // results cleared by reset, rd 3
        bus_read(4'd12, 28'h0000301);     // wr=1 rd=3

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);
        check("cfg_queue_drained", cfg_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
